imem_fetch_ctrl: RTL and testbench

- Instruction-fetch sequencer for the 512 x 33-bit instruction memory.
- The memory has a synchronous read: the address is sampled at a clock edge and the data is valid for the whole following cycle.
- The block owns the PC and drives the memory address. It tracks the one-cycle read latency and buffers fetched words in a 2-entry FIFO.
- It presents words to decode over a valid/ready handshake, and supports branch redirect and end-of-program drain.

---
 rtl/imem_fetch_ctrl.sv | 160 ++++++++++++++++
 tb/tb_imem_fetch_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, tracks the one-cycle synchronous
// read of the instruction memory and buffers fetched words in a 2-entry FIFO.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | after reset; waits for start
// S_FETCH | issuing reads while the credit count allows
// S_DRAIN | last address issued (or redirect past it); emptying the FIFO
// S_DONE  | program drained; start refetches from RESET_PC
module imem_fetch_ctrl #(
  parameter int          ADDR_W    = 9,
  parameter int          DATA_W    = 33,
  parameter int unsigned RESET_PC  = 0,
  parameter int unsigned LAST_ADDR = 511
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_q,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] RESET_VAL = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] LAST_PC   = ADDR_W'(LAST_ADDR);
  // One extra bit keeps the redirect range test meaningful when LAST_PC is all ones.
  localparam logic [ADDR_W:0]   LAST_EXT  = {1'b0, LAST_PC};

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] tag_q, tag_d;
  logic [DATA_W-1:0] fifo_data_q [2];
  logic [DATA_W-1:0] fifo_data_d [2];
  logic [ADDR_W-1:0] fifo_pc_q [2];
  logic [ADDR_W-1:0] fifo_pc_d [2];
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic [1:0]        count_q, count_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              running;
  logic              flush;
  logic              pop;
  logic              push;
  logic              issue;
  logic [1:0]        credit;

  always_comb begin
    running = (state_q == S_FETCH) || (state_q == S_DRAIN);
    flush   = running && redirect_valid;
    pop     = (count_q != 2'd0) && instr_ready && !flush;
    push    = inflight_q && !flush;
    // Slots already claimed once this cycle's pop is taken into account.
    credit  = {1'b0, inflight_q} + count_q - {1'b0, pop};
    issue   = (state_q == S_FETCH) && !redirect_valid && (credit < 2'd2);

    state_d     = state_q;
    pc_d        = pc_q;
    inflight_d  = issue;
    tag_d       = tag_q;
    fifo_data_d = fifo_data_q;
    fifo_pc_d   = fifo_pc_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q + {1'b0, push} - {1'b0, pop};

    if (push) begin
      fifo_data_d[wr_ptr_q] = imem_q;
      fifo_pc_d[wr_ptr_q]   = tag_q;
      wr_ptr_d              = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    if (issue) begin
      tag_d = pc_q;
      if (pc_q == LAST_PC) begin
        state_d = S_DRAIN;
      end else begin
        pc_d = pc_q + 1'b1;
      end
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_FETCH;
          pc_d    = RESET_VAL;
        end
      end
      S_DRAIN: begin
        if (!inflight_d && (count_d == 2'd0)) begin
          state_d = S_DONE;
        end
      end
      default: ;
    endcase

    // Redirect wins over issue, capture and pop: the in-flight read is dropped.
    if (flush) begin
      count_d    = 2'd0;
      rd_ptr_d   = 1'b0;
      wr_ptr_d   = 1'b0;
      inflight_d = 1'b0;
      pc_d       = redirect_addr;
      state_d    = ({1'b0, redirect_addr} <= LAST_EXT) ? S_FETCH : S_DRAIN;
    end

    busy_d = (state_d == S_FETCH) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_VAL;
      inflight_q  <= 1'b0;
      tag_q       <= '0;
      fifo_data_q <= '{default: '0};
      fifo_pc_q   <= '{default: '0};
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      inflight_q  <= inflight_d;
      tag_q       <= tag_d;
      fifo_data_q <= fifo_data_d;
      fifo_pc_q   <= fifo_pc_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign imem_addr   = pc_q;
  assign instr_valid = (count_q != 2'd0) && !flush;
  assign instr_data  = fifo_data_q[rd_ptr_q];
  assign instr_pc    = fifo_pc_q[rd_ptr_q];
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: two instances (short and full program) driven in
// lockstep and checked every cycle against a queue-level model of the fetch rules.
module tb_imem_fetch_ctrl;
  localparam int AW     = 9;
  localparam int DW     = 33;
  localparam int LAST_A = 5;
  localparam int LAST_B = 511;

  localparam int M_IDLE  = 0;
  localparam int M_FETCH = 1;
  localparam int M_DRAIN = 2;
  localparam int M_DONE  = 3;

  logic          clock = 1'b0;
  logic          reset, start, redirect_valid, instr_ready;
  logic [AW-1:0] redirect_addr;
  logic [DW-1:0] mem [512];

  logic [AW-1:0] addr_a, addr_b, ipc_a, ipc_b;
  logic [DW-1:0] q_a, q_b, data_a, data_b;
  logic          val_a, val_b, busy_a, busy_b, done_a, done_b;

  int vectors = 0;
  int errors  = 0;

  // model state, index 0 = instance a, 1 = instance b
  int            m_mode [2];
  int            m_pc   [2];
  int            m_infl [2];
  int            m_tag  [2];
  int            m_sz   [2];
  int            m_fpc  [2][3];
  logic [DW-1:0] m_fdat [2][3];

  always #5 clock = ~clock;

  // synchronous-read memory for each instance
  always @(posedge clock) begin
    q_a <= mem[addr_a];
    q_b <= mem[addr_b];
  end

  imem_fetch_ctrl #(.LAST_ADDR(LAST_A)) dut_a (
    .clock(clock), .reset(reset), .start(start),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .imem_addr(addr_a), .imem_q(q_a),
    .instr_valid(val_a), .instr_data(data_a), .instr_pc(ipc_a),
    .instr_ready(instr_ready), .busy(busy_a), .done(done_a)
  );

  imem_fetch_ctrl #(.LAST_ADDR(LAST_B)) dut_b (
    .clock(clock), .reset(reset), .start(start),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .imem_addr(addr_b), .imem_q(q_b),
    .instr_valid(val_b), .instr_data(data_b), .instr_pc(ipc_b),
    .instr_ready(instr_ready), .busy(busy_b), .done(done_b)
  );

  function automatic int last_of(int k);
    return (k == 0) ? LAST_A : LAST_B;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit exp_valid(int k);
    bit running = (m_mode[k] == M_FETCH) || (m_mode[k] == M_DRAIN);
    return (m_sz[k] > 0) && !(running && redirect_valid);
  endfunction

  task automatic model_check(int k, logic v, logic [DW-1:0] d, logic [AW-1:0] p,
                             logic [AW-1:0] a, logic b, logic dn);
    string pre = (k == 0) ? "a" : "b";
    bit ev = exp_valid(k);
    chk({pre, ".instr_valid"}, 64'(v), 64'(ev));
    if (ev) begin
      chk({pre, ".instr_data"}, 64'(d), 64'(m_fdat[k][0]));
      chk({pre, ".instr_pc"}, 64'(p), 64'(m_fpc[k][0]));
    end
    chk({pre, ".imem_addr"}, 64'(a), 64'(m_pc[k]));
    chk({pre, ".busy"}, 64'(b), 64'((m_mode[k] == M_FETCH) || (m_mode[k] == M_DRAIN)));
    chk({pre, ".done"}, 64'(dn), 64'(m_mode[k] == M_DONE));
  endtask

  // advance model k by one clock edge using the inputs currently applied
  task automatic model_step(int k);
    int last = last_of(k);
    bit running, pop, iss, was_drain, was_parked;
    if (reset) begin
      m_mode[k] = M_IDLE; m_pc[k] = 0; m_infl[k] = 0; m_sz[k] = 0;
      return;
    end
    running = (m_mode[k] == M_FETCH) || (m_mode[k] == M_DRAIN);
    if (running && redirect_valid) begin
      m_sz[k] = 0; m_infl[k] = 0; m_pc[k] = int'(redirect_addr);
      m_mode[k] = (int'(redirect_addr) <= last) ? M_FETCH : M_DRAIN;
      return;
    end
    was_drain  = (m_mode[k] == M_DRAIN);
    was_parked = (m_mode[k] == M_IDLE) || (m_mode[k] == M_DONE);
    pop = (m_sz[k] > 0) && instr_ready;
    iss = (m_mode[k] == M_FETCH) && (m_pc[k] <= last) &&
          (m_infl[k] + m_sz[k] - int'(pop) < 2);
    if (pop) begin
      for (int i = 0; i < 2; i++) begin
        m_fpc[k][i] = m_fpc[k][i+1]; m_fdat[k][i] = m_fdat[k][i+1];
      end
      m_sz[k]--;
    end
    if (m_infl[k] != 0) begin
      if (m_sz[k] == 2) begin
        errors++;
        $display("FAIL model_overflow: inst %0d pushes into a full 2-entry FIFO", k);
      end else begin
        m_fpc[k][m_sz[k]] = m_tag[k]; m_fdat[k][m_sz[k]] = mem[m_tag[k]];
        m_sz[k]++;
      end
    end
    m_infl[k] = int'(iss);
    if (iss) begin
      m_tag[k] = m_pc[k];
      if (m_pc[k] == last) m_mode[k] = M_DRAIN;
      else m_pc[k] = m_pc[k] + 1;
    end
    if (was_drain && m_infl[k] == 0 && m_sz[k] == 0) m_mode[k] = M_DONE;
    if (was_parked && start) begin
      m_mode[k] = M_FETCH; m_pc[k] = 0;
    end
  endtask

  // compare on the falling edge, then step the model across the next rising edge
  task automatic cycle();
    @(negedge clock);
    model_check(0, val_a, data_a, ipc_a, addr_a, busy_a, done_a);
    model_check(1, val_b, data_b, ipc_b, addr_b, busy_b, done_b);
    if (!reset && dut_a.push && !dut_a.pop && dut_a.count_q == 2'd2) begin
      errors++; $display("FAIL fifo_overflow: instance a pushed while full");
    end
    if (!reset && dut_b.push && !dut_b.pop && dut_b.count_q == 2'd2) begin
      errors++; $display("FAIL fifo_overflow: instance b pushed while full");
    end
    model_step(0);
    model_step(1);
    @(posedge clock);
    #1;
  endtask

  task automatic drive(bit rst, bit st, bit rv, int ra, bit rdy);
    reset = rst; start = st; redirect_valid = rv;
    redirect_addr = AW'(ra); instr_ready = rdy;
  endtask

  task automatic reset_both();
    drive(1, 0, 0, 0, 1);
    cycle();
    cycle();
  endtask

  // start then stream 0..LAST_A with ready high; a start pulse mid-run must be ignored
  task automatic run_seq1(string tag);
    drive(0, 1, 0, 0, 1);
    cycle();
    chk({tag, ".addr0"}, 64'(addr_a), 64'd0);
    chk({tag, ".valid_start"}, 64'(val_a), 64'd0);
    for (int c = 1; c <= 8; c++) begin
      drive(0, (c == 3), 0, 0, 1);
      cycle();
      if (c <= 5) chk({tag, ".addr_step"}, 64'(addr_a), 64'(c));
      if (c == 1) chk({tag, ".valid_latency"}, 64'(val_a), 64'd0);
      if (c >= 2 && c <= 7) begin
        chk({tag, ".valid"}, 64'(val_a), 64'd1);
        chk({tag, ".pc_seq"}, 64'(ipc_a), 64'(c - 2));
        chk({tag, ".data_seq"}, 64'(data_a), 64'(mem[c - 2]));
      end
      if (c == 7) chk({tag, ".busy_last"}, 64'(busy_a), 64'd1);
      if (c == 8) begin
        chk({tag, ".done"}, 64'(done_a), 64'd1);
        chk({tag, ".busy_end"}, 64'(busy_a), 64'd0);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = {1'($urandom), 32'($urandom)};
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = M_IDLE; m_pc[k] = 0; m_infl[k] = 0; m_tag[k] = 0; m_sz[k] = 0;
    end
    drive(1, 0, 0, 0, 1);
    @(posedge clock); #1;
    reset_both();
    chk("rst.valid", 64'(val_a), 64'd0);
    chk("rst.data", 64'(data_a), 64'd0);
    chk("rst.pc", 64'(ipc_a), 64'd0);
    chk("rst.addr", 64'(addr_a), 64'd0);
    chk("rst.busy_done", 64'({busy_a, done_a}), 64'd0);

    run_seq1("s1");

    // ready low: two reads, then hold with pc 0 at the head
    drive(0, 1, 0, 0, 0);
    cycle();
    drive(0, 0, 0, 0, 0);
    for (int c = 1; c <= 4; c++) begin
      cycle();
      chk("s2.addr_hold", 64'(addr_a), 64'((c < 2) ? c : 2));
      if (c >= 2) begin
        chk("s2.valid", 64'(val_a), 64'd1);
        chk("s2.pc_stable", 64'(ipc_a), 64'd0);
        chk("s2.data_stable", 64'(data_a), 64'(mem[0]));
      end
    end
    for (int j = 1; j <= 5; j++) begin
      drive(0, 0, 0, 0, 1);
      cycle();
      chk("s2.pc_order", 64'(ipc_a), 64'(j));
    end
    cycle();
    chk("s2.done", 64'(done_a), 64'd1);

    run_seq1("s6");

    // redirect to 16 while pc 2 is at the head of instance b
    reset_both();
    drive(0, 1, 0, 0, 1);
    cycle();
    drive(0, 0, 0, 0, 1);
    for (int c = 1; c <= 4; c++) cycle();
    chk("s3.head_pc2", 64'(ipc_b), 64'd2);
    drive(0, 0, 1, 16, 1);
    #1;
    chk("s3.valid_killed", 64'(val_b), 64'd0);
    cycle();
    drive(0, 0, 0, 0, 1);
    cycle();
    chk("s3.no_stale", 64'(val_b), 64'd0);
    cycle();
    chk("s3.target_valid", 64'(val_b), 64'd1);
    chk("s3.target_pc", 64'(ipc_b), 64'd16);
    chk("s3.target_data", 64'(data_b), 64'(mem[16]));
    cycle();
    chk("s3.next_pc", 64'(ipc_b), 64'd17);

    // redirect beyond LAST_A on instance a: drain then done
    reset_both();
    drive(0, 1, 0, 0, 1);
    cycle();
    drive(0, 0, 0, 0, 1);
    cycle();
    cycle();
    drive(0, 0, 1, 100, 1);
    cycle();
    chk("s4.valid_r", 64'(val_a), 64'd0);
    chk("s4.busy_r", 64'(busy_a), 64'd1);
    drive(0, 0, 0, 0, 1);
    cycle();
    chk("s4.valid_r1", 64'(val_a), 64'd0);
    cycle();
    chk("s4.done", 64'(done_a), 64'd1);
    chk("s4.valid_r2", 64'(val_a), 64'd0);

    // reset with a word buffered and a read in flight
    reset_both();
    drive(0, 1, 0, 0, 0);
    cycle();
    drive(0, 0, 0, 0, 0);
    cycle();
    cycle();
    drive(1, 0, 0, 0, 0);
    cycle();
    chk("s5.valid", 64'(val_a), 64'd0);
    chk("s5.busy", 64'(busy_a), 64'd0);
    chk("s5.addr", 64'(addr_a), 64'd0);
    drive(0, 1, 0, 0, 1);
    cycle();
    drive(0, 0, 0, 0, 1);
    cycle();
    chk("s5.no_stale", 64'(val_a), 64'd0);
    cycle();
    chk("s5.first_pc", 64'(ipc_a), 64'd0);
    chk("s5.first_data", 64'(data_a), 64'(mem[0]));

    // randomized traffic, model-checked every cycle
    for (int n = 0; n < 3000; n++) begin
      int  sel;
      int  ra;
      sel = int'($urandom_range(2, 0));
      ra  = (sel == 0) ? int'($urandom_range(7, 0)) :
            (sel == 1) ? int'($urandom_range(511, 505)) : int'($urandom_range(511, 0));
      drive(($urandom_range(199, 0) == 0), ($urandom_range(9, 0) == 0),
            ($urandom_range(24, 0) == 0), ra, ($urandom_range(3, 0) != 0));
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
